// File: rtl/zorro_arb_pkg.sv
// Zorro III bus arbiter shared definitions.
// State encoding and default parameter values.
package zorro_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_IDLE,
    ST_OWN,
    ST_RELEASE,
    ST_BACKOFF
  } arb_state_e;

  localparam int GRANT_TIMEOUT_DEF  = 255;
  localparam int BACKOFF_CYCLES_DEF = 16;
  localparam int SYNC_STAGES_DEF    = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/zorro_sync.sv
// N-stage single-bit synchroniser.
// Resets to 1, the idle level of active-low bus strobes.
module zorro_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  // shift the asynchronous input through the flop chain
  always_ff @(posedge clk_i) begin
    if (rst_i) ff_q <= '1;
    else       ff_q <= {ff_q[STAGES-2:0], d_i};
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/zorro_bus_arbiter.sv
// Zorro III bus mastership arbiter for the SCSI DMA engine.
// BR/BG/BGACK handshake with grant watchdog and back-off.
module zorro_bus_arbiter
  import zorro_arb_pkg::*;
#(
  parameter int GRANT_TIMEOUT  = GRANT_TIMEOUT_DEF,
  parameter int BACKOFF_CYCLES = BACKOFF_CYCLES_DEF,
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic SCSI_BR_n,
  input  logic ZORRO_BG_n,
  input  logic ZORRO_FCS_n,
  input  logic ZORRO_DTACK_n,
  input  logic DMA_BFCS,
  output logic ZORRO_BR_n,
  output logic ZORRO_BGACK_n,
  output logic SCSI_BG_n,
  output logic BMASTER,
  output logic ARB_TIMEOUT
);

  localparam int CW =
    $clog2(max2(GRANT_TIMEOUT, BACKOFF_CYCLES) + 1);
  localparam logic [CW-1:0] GT_LAST  = CW'(GRANT_TIMEOUT - 1);
  localparam logic [CW-1:0] BO_LAST  = CW'(BACKOFF_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic br, bg, fcs, dtack;

  zorro_sync #(.STAGES(SYNC_STAGES)) u_sync_br (
    .clk_i(CLK), .rst_i(RESET), .d_i(SCSI_BR_n), .q_o(br)
  );
  zorro_sync #(.STAGES(SYNC_STAGES)) u_sync_bg (
    .clk_i(CLK), .rst_i(RESET), .d_i(ZORRO_BG_n), .q_o(bg)
  );
  zorro_sync #(.STAGES(SYNC_STAGES)) u_sync_fcs (
    .clk_i(CLK), .rst_i(RESET), .d_i(ZORRO_FCS_n), .q_o(fcs)
  );
  zorro_sync #(.STAGES(SYNC_STAGES)) u_sync_dtack (
    .clk_i(CLK), .rst_i(RESET), .d_i(ZORRO_DTACK_n), .q_o(dtack)
  );

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          br_n_q, br_n_d;
  logic          bgack_n_q, bgack_n_d;
  logic          sbg_n_q, sbg_n_d;
  logic          bm_q, bm_d;
  logic          to_q, to_d;

  // next state, shared counter and next-cycle output decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!br) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (br)                  state_d = ST_IDLE;
        else if (!bg)            state_d = ST_WAIT_IDLE;
        else if (cnt_q == GT_LAST) state_d = ST_BACKOFF;
      end
      ST_WAIT_IDLE: begin
        if (bg)              state_d = ST_REQ;
        else if (br)         state_d = ST_IDLE;
        else if (fcs && dtack) state_d = ST_OWN;
      end
      ST_OWN: begin
        if (br) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!DMA_BFCS) state_d = ST_IDLE;
      end
      ST_BACKOFF: begin
        if (cnt_q == BO_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if ((state_q == ST_REQ || state_q == ST_BACKOFF)
             && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;

    br_n_d    = !(state_d == ST_REQ || state_d == ST_WAIT_IDLE);
    bgack_n_d = !(state_d == ST_OWN || state_d == ST_RELEASE);
    sbg_n_d   = !(state_d == ST_OWN);
    bm_d      = (state_d == ST_OWN || state_d == ST_RELEASE);
    to_d      = (state_d == ST_BACKOFF) && (state_q != ST_BACKOFF);
  end

  // state, counter and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      br_n_q    <= 1'b1;
      bgack_n_q <= 1'b1;
      sbg_n_q   <= 1'b1;
      bm_q      <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      br_n_q    <= br_n_d;
      bgack_n_q <= bgack_n_d;
      sbg_n_q   <= sbg_n_d;
      bm_q      <= bm_d;
      to_q      <= to_d;
    end
  end

  assign ZORRO_BR_n    = br_n_q;
  assign ZORRO_BGACK_n = bgack_n_q;
  assign SCSI_BG_n     = sbg_n_q;
  assign BMASTER       = bm_q;
  assign ARB_TIMEOUT   = to_q;

endmodule
